// File: rtl/tych_ing_fbuf.sv
// tych_ing_fbuf: store-and-forward ingress frame buffer between tych_ing core_avl_out and the packet buffer.
// Ports: clk, rst (async, active-low); in_* beat stream with in_ready (never deasserted
// outside reset); out_* beat stream with out_ready; frames_avail committed frame count;
// drop_ovf_cnt/drop_fmt_cnt/drop_err_cnt saturating drop counters.
// Optional: TYCH_ING_FBUF_ERR_DROP_EN drops frames whose eop beat carries in_err.
module tych_ing_fbuf #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 512,
  parameter int CNT_W = 16,
  localparam int EMPTY_W = $clog2(DATA_W / 8),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sop,
  input  logic               in_eop,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               in_err,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic               out_err,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic [AW:0]        frames_avail,
  output logic [CNT_W-1:0]   drop_ovf_cnt,
  output logic [CNT_W-1:0]   drop_fmt_cnt,
  output logic [CNT_W-1:0]   drop_err_cnt
);
  localparam int EW = 3 + EMPTY_W + DATA_W;
  typedef enum logic [1:0] {IDLE, STORE, DISCARD} st_t;
  st_t st, st_nxt;
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, base, wr_nxt, cm_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic acc, we, commit, inc_ovf, inc_fmt, inc_err, drop_e, avail, ld, rd_eop;
`ifdef TYCH_ING_FBUF_ERR_DROP_EN
  assign drop_e = in_err;
`else
  assign drop_e = 1'b0;
`endif
  assign acc = in_valid && in_ready;
  // a sop arriving mid-frame restarts at the last commit point, so the stale partial frame is overwritten
  assign base = (st == STORE && in_sop) ? commit_ptr : wr_ptr;
  always_comb begin
    st_nxt = st;
    wr_nxt = wr_ptr;
    cm_nxt = commit_ptr;
    we = 1'b0;
    commit = 1'b0;
    inc_ovf = 1'b0;
    inc_fmt = 1'b0;
    inc_err = 1'b0;
    if (acc) begin
      if (in_sop || st == STORE) begin
        inc_fmt = st == STORE && in_sop;
        if (base - rd_ptr == (AW+1)'(DEPTH)) begin
          inc_ovf = 1'b1;
          wr_nxt = commit_ptr;
          st_nxt = in_eop ? IDLE : DISCARD;
        end else begin
          we = 1'b1;
          wr_nxt = base + 1'b1;
          st_nxt = in_eop ? IDLE : STORE;
          if (in_eop && drop_e) begin
            inc_err = 1'b1;
            wr_nxt = commit_ptr;
          end else if (in_eop) begin
            commit = 1'b1;
            cm_nxt = base + 1'b1;
          end
        end
      end else if (st == DISCARD && in_eop) begin
        st_nxt = IDLE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[base[AW-1:0]] <= {in_sop, in_eop, in_err & in_eop, in_empty, in_data};
  end
  // output register reloads straight from the committed region whenever it is empty or being consumed
  assign avail = rd_ptr != commit_ptr;
  assign ld = !out_valid || out_ready;
  assign rd_eop = out_valid && out_ready && out_eop;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      {out_sop, out_eop, out_err, out_empty, out_data} <= '0;
      frames_avail <= '0;
      drop_ovf_cnt <= '0;
      drop_fmt_cnt <= '0;
      drop_err_cnt <= '0;
    end else begin
      st <= st_nxt;
      wr_ptr <= wr_nxt;
      commit_ptr <= cm_nxt;
      in_ready <= 1'b1;
      if (ld) out_valid <= avail;
      if (ld && avail) begin
        {out_sop, out_eop, out_err, out_empty, out_data} <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
      frames_avail <= (commit && !rd_eop) ? frames_avail + 1'b1 :
                      (!commit && rd_eop) ? frames_avail - 1'b1 : frames_avail;
      drop_ovf_cnt <= drop_ovf_cnt + CNT_W'(inc_ovf && !(&drop_ovf_cnt));
      drop_fmt_cnt <= drop_fmt_cnt + CNT_W'(inc_fmt && !(&drop_fmt_cnt));
      drop_err_cnt <= drop_err_cnt + CNT_W'(inc_err && !(&drop_err_cnt));
    end
  end
endmodule

// File: tb/tb_tych_ing_fbuf.sv
// tb_tych_ing_fbuf: directed self-checking bench for tych_ing_fbuf (DEPTH=16).
module tb_tych_ing_fbuf;
  localparam int DW = 64, MW = 3, DEP = 16, CW = 16, FW = 5;
`ifdef TYCH_ING_FBUF_ERR_DROP_EN
  localparam bit ED = 1'b1;
`else
  localparam bit ED = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
  logic [MW-1:0] in_empty = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_sop, out_eop, out_err;
  logic out_ready = 1'b1;
  logic [MW-1:0] out_empty;
  logic [DW-1:0] out_data;
  logic [FW-1:0] frames_avail;
  logic [CW-1:0] drop_ovf_cnt, drop_fmt_cnt, drop_err_cnt;
  tych_ing_fbuf #(.DATA_W(DW), .DEPTH(DEP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_empty(in_empty),
    .in_err(in_err), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
    .out_empty(out_empty), .out_data(out_data), .out_ready(out_ready),
    .frames_avail(frames_avail), .drop_ovf_cnt(drop_ovf_cnt),
    .drop_fmt_cnt(drop_fmt_cnt), .drop_err_cnt(drop_err_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, failures = 0;
  int first_cyc = -1, eop_cyc = 0;
  logic tgl = 1'b0, pst = 1'b0;
  logic [69:0] pbeat, q[$], exp_q[$];
  wire [69:0] obeat = {out_sop, out_eop, out_err, out_empty, out_data};
  always @(negedge clk) begin
    if (rst && pst) begin
      checks++;
      assert ({out_valid, obeat} === {1'b1, pbeat}) else begin
        failures++;
        $error("FAIL stall_hold obs=%0h exp=%0h", {out_valid, obeat}, {1'b1, pbeat});
      end
    end
    pst = rst && out_valid && !out_ready;
    pbeat = obeat;
    if (rst && out_valid && first_cyc < 0) first_cyc = cyc;
    if (rst && out_valid && out_ready) q.push_back(obeat);
  end
  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    if (tgl) out_ready = ~out_ready;
  endtask
  task automatic beat(input logic s, input logic e, input logic r, input logic [MW-1:0] m, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_sop = s;
    in_eop = e;
    in_err = r;
    in_empty = m;
    in_data = d;
    chk("in_ready", in_ready, 1);
    if (e) eop_cyc = cyc;
    step();
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_err = 1'b0;
  endtask
  task automatic frame(input int n, input logic [DW-1:0] b, input logic [DW-1:0] stp, input logic [MW-1:0] em, input logic er, input logic keep);
    for (int i = 0; i < n; i++) begin
      logic s, e, r;
      logic [MW-1:0] m;
      logic [DW-1:0] d;
      s = i == 0;
      e = i == n - 1;
      r = e & er;
      m = e ? em : '0;
      d = b + DW'(i) * stp;
      if (keep) exp_q.push_back({s, e, r, m, d});
      beat(s, e, r, m, d);
    end
  endtask
  task automatic drain_cmp(input string tag);
    repeat (60) step();
    chk({tag, "_count"}, q.size(), exp_q.size());
    for (int i = 0; i < q.size() && i < exp_q.size(); i++) chk({tag, "_beat"}, q[i], exp_q[i]);
    q.delete();
    exp_q.delete();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, obeat, frames_avail, drop_ovf_cnt, drop_fmt_cnt, drop_err_cnt, in_ready}, 0);
    rst = 1'b1;
    step();
    chk("in_ready_up", in_ready, 1);
    // single 4-beat frame, full-rate drain
    frame(4, 64'h11, 64'h11, 3'd3, 1'b0, 1'b1);
    chk("fa_commit", frames_avail, 1);
    drain_cmp("single");
    chk("latency_min", (first_cyc - eop_cyc) >= 2, 1);
    chk("latency_max", (first_cyc - eop_cyc) <= 4, 1);
    chk("fa_drained", frames_avail, 0);
    // overflow of second frame with the reader stalled
    out_ready = 1'b0;
    frame(10, 64'h100, 64'h1, 3'd0, 1'b0, 1'b1);
    frame(10, 64'h200, 64'h1, 3'd0, 1'b0, 1'b0);
    step();
    chk("ovf_cnt", drop_ovf_cnt, 1);
    chk("ovf_fa", frames_avail, 1);
    out_ready = 1'b1;
    drain_cmp("ovf");
    chk("ovf_fa_drained", frames_avail, 0);
    // missing eop followed by a complete frame
    beat(1'b1, 1'b0, 1'b0, 3'd0, 64'h300);
    beat(1'b0, 1'b0, 1'b0, 3'd0, 64'h301);
    beat(1'b0, 1'b0, 1'b0, 3'd0, 64'h302);
    frame(3, 64'h310, 64'h1, 3'd5, 1'b0, 1'b1);
    drain_cmp("fmt");
    chk("fmt_cnt", drop_fmt_cnt, 1);
    chk("fmt_ovf_cnt", drop_ovf_cnt, 1);
    // errored frame
    frame(5, 64'h400, 64'h1, 3'd2, 1'b1, !ED);
    drain_cmp("err");
    chk("err_cnt", drop_err_cnt, ED ? 1 : 0);
    // back-to-back frames under toggling backpressure
    tgl = 1'b1;
    frame(2, 64'h500, 64'h1, 3'd1, 1'b0, 1'b1);
    frame(7, 64'h600, 64'h1, 3'd4, 1'b0, 1'b1);
    frame(1, 64'h700, 64'h1, 3'd7, 1'b0, 1'b1);
    drain_cmp("bp");
    tgl = 1'b0;
    out_ready = 1'b1;
    chk("bp_fa", frames_avail, 0);
    // reset in the middle of a frame
    beat(1'b1, 1'b0, 1'b0, 3'd0, 64'h800);
    beat(1'b0, 1'b0, 1'b0, 3'd0, 64'h801);
    in_valid = 1'b1;
    in_data = 64'h802;
    rst = 1'b0;
    #1;
    chk("reset_mid", {out_valid, obeat, frames_avail, drop_ovf_cnt, drop_fmt_cnt, drop_err_cnt, in_ready}, 0);
    step();
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    beat(1'b0, 1'b0, 1'b0, 3'd0, 64'h803);
    beat(1'b0, 1'b0, 1'b0, 3'd0, 64'h804);
    beat(1'b0, 1'b1, 1'b0, 3'd0, 64'h805);
    frame(2, 64'h900, 64'h1, 3'd6, 1'b0, 1'b1);
    drain_cmp("rst");
    chk("rst_cnts", {drop_ovf_cnt, drop_fmt_cnt, drop_err_cnt}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
